// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// req0 (ALU) and req1 (LSU) compete through valid/ready handshakes. The
// granted request is registered onto the RegFile port one cycle later. A
// busy scoreboard tracks registers that still have a pending write.
module regfile_wb_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AW-1:0]        req0_addr,
  input  logic [DW-1:0]        req0_data,
  input  logic [1:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AW-1:0]        req1_addr,
  input  logic [DW-1:0]        req1_data,
  input  logic [1:0]           req1_op,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic [(1<<AW)-1:0]   sb_busy,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [1:0]           rf_wen,
  output logic [15:0]          wr_count
);
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    op;
  } wbReq_t;

  logic   lastGrant;  // 1 = req1 was granted last, so req0 wins the next tie
  logic   grant0, grant1, xfer, doWrite;
  wbReq_t selReq;
  logic [DW-1:0] selData;

  // Grant selection; ready is held low during reset so nothing is consumed
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && !req1_valid)       grant0 = 1'b1;
      else if (!req0_valid && req1_valid)  grant1 = 1'b1;
      else if (req0_valid && req1_valid) begin
        if (ARB_MODE == 1 || lastGrant)    grant0 = 1'b1;
        else                               grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;

  // Mux the winner and resolve the constant-data op codes
  always_comb begin
    selReq = grant1 ? '{addr: req1_addr, data: req1_data, op: req1_op}
                    : '{addr: req0_addr, data: req0_data, op: req0_op};
    case (selReq.op)
      2'b01:   selData = {{(DW-1){1'b0}}, 1'b1};
      2'b10:   selData = '0;
      default: selData = selReq.data;
    endcase
    doWrite = xfer && (selReq.op != 2'b00);
  end

  // Registered write port; a no-op transfer behaves like an idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 2'b00;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= doWrite ? selReq.op : 2'b00;
      if (doWrite) begin
        rf_waddr <= selReq.addr;
        rf_wdata <= selData;
      end
    end
  end

  // Round-robin pointer moves only on an accepted transfer
  always_ff @(posedge clk) begin
    if (rst)       lastGrant <= 1'b1;
    else if (xfer) lastGrant <= grant1;
  end

  // Scoreboard: a committed write clears its bit, a new producer re-sets it
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (sb_set && sb_addr == AW'(i))                sb_busy[i] <= 1'b1;
        else if (doWrite && selReq.addr == AW'(i))      sb_busy[i] <= 1'b0;
      end
    end
  end

  // Committed-write counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)          wr_count <= '0;
    else if (doWrite) wr_count <= wr_count + 16'd1;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: one round-robin and one fixed-priority instance share
// all stimulus so both arbitration modes are observed side by side.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, sbSet;
  logic [3:0]  a0, a1, sbAddr;
  logic [31:0] d0, d1;
  logic [1:0]  o0, o1;

  logic        rdy0A, rdy1A, rdy0B, rdy1B;
  logic [15:0] busyA, busyB, cntA, cntB;
  logic [3:0]  waddrA, waddrB;
  logic [31:0] wdataA, wdataB;
  logic [1:0]  wenA, wenB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.AW(4), .DW(32), .ARB_MODE(0)) uRr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0A), .req0_addr(a0), .req0_data(d0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(rdy1A), .req1_addr(a1), .req1_data(d1), .req1_op(o1),
    .sb_set(sbSet), .sb_addr(sbAddr), .sb_busy(busyA),
    .rf_waddr(waddrA), .rf_wdata(wdataA), .rf_wen(wenA), .wr_count(cntA));

  regfile_wb_arbiter #(.AW(4), .DW(32), .ARB_MODE(1)) uFix (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0B), .req0_addr(a0), .req0_data(d0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(rdy1B), .req1_addr(a1), .req1_data(d1), .req1_op(o1),
    .sb_set(sbSet), .sb_addr(sbAddr), .sb_busy(busyB),
    .rf_waddr(waddrB), .rf_wdata(wdataB), .rf_wen(wenB), .wr_count(cntB));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; sbSet = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0; o0 = 0; o1 = 0; sbAddr = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    // 1: reset with both requesters valid
    v0 = 1; v1 = 1; o0 = 2'b11; o1 = 2'b11;
    #1;
    chk("rst_rdy0", {31'd0, rdy0A}, 32'd0);
    chk("rst_rdy1", {31'd0, rdy1A}, 32'd0);
    tick(); tick();
    chk("rst_wen",   {30'd0, wenA}, 32'd0);
    chk("rst_busy",  {16'd0, busyA}, 32'd0);
    chk("rst_cnt",   {16'd0, cntA}, 32'd0);
    chk("rst_waddr", {28'd0, waddrA}, 32'd0);
    chk("rst_wdata", wdataA, 32'd0);
    chk("rst_rdyB",  {30'd0, rdy0B, rdy1B}, 32'd0);
    idle();
    rst = 0;

    // 2: single ALU write
    v0 = 1; a0 = 4'd3; d0 = 32'h1234_5678; o0 = 2'b11;
    #1;
    chk("t2_rdy0", {31'd0, rdy0A}, 32'd1);
    tick();
    v0 = 0;
    chk("t2_waddr", {28'd0, waddrA}, 32'd3);
    chk("t2_wdata", wdataA, 32'h1234_5678);
    chk("t2_wen",   {30'd0, wenA}, 32'd3);
    tick();
    chk("t2_wen_idle", {30'd0, wenA}, 32'd0);
    chk("t2_cnt",      {16'd0, cntA}, 32'd1);

    // Re-reset so the round-robin pointer starts from its reset preference
    rst = 1; tick(); rst = 0;

    // 3/4: contention for 4 cycles, round-robin vs fixed priority
    v0 = 1; a0 = 4'd1; d0 = 32'hAAAA_0001; o0 = 2'b11;
    v1 = 1; a1 = 4'd2; d1 = 32'hBBBB_0002; o1 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), {31'd0, rdy0A}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_rdy1_%0d", i), {31'd0, rdy1A}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("fp_rdy_%0d", i), {30'd0, rdy0B, rdy1B}, 32'd2);
      @(posedge clk); #1;
      chk($sformatf("rr_waddr_%0d", i), {28'd0, waddrA}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr_wdata_%0d", i), wdataA, (i % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
      chk($sformatf("fp_waddr_%0d", i), {28'd0, waddrB}, 32'd1);
    end
    idle();
    tick();
    chk("t3_cnt_rr",  {16'd0, cntA}, 32'd4);
    chk("t4_cnt_fp",  {16'd0, cntB}, 32'd4);
    chk("t3_wen_idle", {30'd0, wenA}, 32'd0);

    // 5: scoreboard set, then LSU clears it with op=10
    sbSet = 1; sbAddr = 4'd5;
    tick();
    sbSet = 0;
    chk("t5_busy_set", {31'd0, busyA[5]}, 32'd1);
    tick();
    chk("t5_busy_hold", {31'd0, busyA[5]}, 32'd1);
    v1 = 1; a1 = 4'd5; d1 = 32'hFFFF_FFFF; o1 = 2'b10;
    #1;
    chk("t5_rdy1", {31'd0, rdy1A}, 32'd1);
    tick();
    chk("t5_busy_clr", {31'd0, busyA[5]}, 32'd0);
    chk("t5_wen",   {30'd0, wenA}, 32'd2);
    chk("t5_wdata", wdataA, 32'd0);
    chk("t5_waddr", {28'd0, waddrA}, 32'd5);
    // set and clear on the same register in one cycle: set wins; op=01 writes 1
    o1 = 2'b01; sbSet = 1; sbAddr = 4'd5;
    tick();
    idle();
    chk("t5_set_wins", {31'd0, busyA[5]}, 32'd1);
    chk("t5_wen01",   {30'd0, wenA}, 32'd1);
    chk("t5_wdata01", wdataA, 32'd1);
    chk("t5_cnt",     {16'd0, cntA}, 32'd6);

    // 6: no-op transfer leaves scoreboard, counter and port data alone
    sbSet = 1; sbAddr = 4'd7;
    tick();
    sbSet = 0;
    chk("t6_busy7", {31'd0, busyA[7]}, 32'd1);
    v0 = 1; a0 = 4'd7; d0 = 32'hDEAD_BEEF; o0 = 2'b00;
    #1;
    chk("t6_rdy0", {31'd0, rdy0A}, 32'd1);
    tick();
    chk("t6_wen",   {30'd0, wenA}, 32'd0);
    chk("t6_busy",  {16'd0, busyA}, 32'h0000_00A0);
    chk("t6_cnt",   {16'd0, cntA}, 32'd6);
    chk("t6_waddr", {28'd0, waddrA}, 32'd5);
    chk("t6_wdata", wdataA, 32'd1);
    // reset mid-stream with a live write request
    o0 = 2'b11; a0 = 4'd9; rst = 1;
    #1;
    chk("t6_rst_rdy0", {31'd0, rdy0A}, 32'd0);
    tick();
    chk("t6_rst_wen",   {30'd0, wenA}, 32'd0);
    chk("t6_rst_busy",  {16'd0, busyA}, 32'd0);
    chk("t6_rst_cnt",   {16'd0, cntA}, 32'd0);
    chk("t6_rst_waddr", {28'd0, waddrA}, 32'd0);
    chk("t6_rst_wdata", wdataA, 32'd0);
    chk("t6_rst_cntB",  {16'd0, cntB}, 32'd0);
    idle();
    rst = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
